// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Turns symbolic instructions (op class plus register/immediate fields) into
// the 32-bit words the main decoder expects and streams them into instruction
// memory, one word per cycle, starting at BASE_ADDR. Used by the boot host to
// load a program while the core is still held in reset.

module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    // count value just before memory is full: the write that lands now fills it
    localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W+1:0] CAPACITY  = {2'b01, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_enter_load;

    logic              r_we;          // encoded word waiting on the write port
    logic              r_we_last;     // that word closes the program
    logic [ADDR_W-1:0] r_addr;        // write pointer, points at the word being written
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [ADDR_W:0]   r_count;
    logic              r_last_seen;   // in_last already accepted, stop taking input

    logic [31:0]       w_enc;
    logic              w_op_valid;
    logic [ADDR_W+1:0] w_fill;
    logic              w_accept;
    logic              w_wr_closes;
    logic              w_invalid_last;

    // Words already written plus the one in flight must stay below capacity.
    assign w_fill   = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, r_we};
    assign in_ready = (r_state == ST_LOAD) && !r_last_seen && (w_fill < CAPACITY);
    assign w_accept = in_valid && in_ready;

    // The write in progress ends the session if it carries in_last or fills memory.
    assign w_wr_closes    = r_we && (r_we_last || (r_count == LAST_SLOT));
    // An invalid op produces no write, so its in_last must close the session directly.
    assign w_invalid_last = w_accept && !w_op_valid && in_last;

    // Encode the presented fields into the decoder's instruction format.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_enc      = '0;
        w_op_valid = 1'b1;
        unique case (in_op)
            3'b000:  w_enc = {6'b001111, in_rs, in_rt, in_imm};
            3'b001:  w_enc = {6'b001101, in_rs, in_rt, in_imm};
            3'b010:  w_enc = {6'b110010, in_rs, in_rt, in_rd, 5'b0, 6'b0};
            3'b011:  w_enc = {6'b111011, in_rs, in_rt, in_rd, 5'b0, 6'b0};
            3'b100:  w_enc = {6'b000010, in_target};
            3'b110:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b0};
            default: w_op_valid = 1'b0;
        endcase
    end

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_load = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_LOAD;
                    w_enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (w_wr_closes || w_invalid_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt  = ST_LOAD;
                    w_enter_load = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write port, pointer, counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_we_last   <= 1'b0;
            r_addr      <= BASE;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_we <= w_accept && w_op_valid;
            if (w_accept && w_op_valid) begin
                r_wdata   <= w_enc;
                r_we_last <= in_last;
            end

            if (w_enter_load) begin
                r_addr      <= BASE;
                r_count     <= '0;
                r_err       <= 1'b0;
                r_last_seen <= 1'b0;
            end else begin
                // Pointer wraps naturally at 2**ADDR_W when BASE is non-zero.
                if (r_we) begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= r_count + (ADDR_W+1)'(1);
                end
                if (w_accept && !w_op_valid) begin
                    r_err <= 1'b1;
                end
                if (w_accept && in_last) begin
                    r_last_seen <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader. Three instances cover the default
// geometry, a 4-word memory and a wrapping base address; one is driven at a
// time through shared field wires.

module tb_instr_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        start_t;
    logic        valid_t;
    logic [2:0]  op_t;
    logic [4:0]  rs_t, rt_t, rd_t;
    logic [15:0] imm_t;
    logic [25:0] tgt_t;
    logic        last_t;
    int          sel;

    int n_vec;
    int n_bad;

    // instance a: ADDR_W=8 BASE=0
    logic        a_start, a_valid, a_ready, a_we, a_busy, a_done, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    // instance b: ADDR_W=2 BASE=0
    logic        b_start, b_valid, b_ready, b_we, b_busy, b_done, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;
    // instance c: ADDR_W=8 BASE=0xFE
    logic        c_start, c_valid, c_ready, c_we, c_busy, c_done, c_err;
    logic [7:0]  c_addr;
    logic [31:0] c_wdata;
    logic [8:0]  c_count;

    logic        ready_s, we_s, busy_s, done_s, err_s;
    logic [7:0]  addr_s;
    logic [31:0] wdata_s;
    logic [8:0]  count_s;

    logic [39:0] qa[$];
    logic [39:0] qb[$];
    logic [39:0] qc[$];
    time         ta[$];

    assign a_start = start_t && (sel == 0);
    assign b_start = start_t && (sel == 1);
    assign c_start = start_t && (sel == 2);
    assign a_valid = valid_t && (sel == 0);
    assign b_valid = valid_t && (sel == 1);
    assign c_valid = valid_t && (sel == 2);

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
        .in_op(op_t), .in_rs(rs_t), .in_rt(rt_t), .in_rd(rd_t), .in_imm(imm_t),
        .in_target(tgt_t), .in_last(last_t), .imem_we(a_we), .imem_addr(a_addr),
        .imem_wdata(a_wdata), .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_op(op_t), .in_rs(rs_t), .in_rt(rt_t), .in_rd(rd_t), .in_imm(imm_t),
        .in_target(tgt_t), .in_last(last_t), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
    );

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_valid), .in_ready(c_ready),
        .in_op(op_t), .in_rs(rs_t), .in_rt(rt_t), .in_rd(rd_t), .in_imm(imm_t),
        .in_target(tgt_t), .in_last(last_t), .imem_we(c_we), .imem_addr(c_addr),
        .imem_wdata(c_wdata), .busy(c_busy), .done(c_done), .err(c_err), .count(c_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Route the selected instance's outputs to common names.
    always_comb begin
        ready_s = a_ready; we_s = a_we; busy_s = a_busy; done_s = a_done; err_s = a_err;
        addr_s  = a_addr;  wdata_s = a_wdata; count_s = a_count;
        if (sel == 1) begin
            ready_s = b_ready; we_s = b_we; busy_s = b_busy; done_s = b_done; err_s = b_err;
            addr_s  = {6'b0, b_addr}; wdata_s = b_wdata; count_s = {6'b0, b_count};
        end else if (sel == 2) begin
            ready_s = c_ready; we_s = c_we; busy_s = c_busy; done_s = c_done; err_s = c_err;
            addr_s  = c_addr;  wdata_s = c_wdata; count_s = c_count;
        end
    end

    // Record every imem write, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_we) begin
            qa.push_back({a_addr, a_wdata});
            ta.push_back($time);
        end
        if (b_we) qb.push_back({6'b0, b_addr, b_wdata});
        if (c_we) qc.push_back({c_addr, c_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
    endtask

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        op_t = op; rs_t = rs; rt_t = rt; rd_t = rd; imm_t = imm; tgt_t = tgt; last_t = last;
        valid_t = 1'b1;
        for (int k = 0; k < 20 && !ready_s; k++) tick();
        check("send_ready", ready_s, 1'b1);
        tick();
        valid_t = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20 && !done_s; k++) tick();
        check(tag, done_s, 1'b1);
    endtask

    logic [31:0] exp2[4];

    initial begin
        n_vec = 0; n_bad = 0; sel = 0;
        rst_n = 1'b0; start_t = 1'b0; valid_t = 1'b0;
        op_t = '0; rs_t = '0; rt_t = '0; rd_t = '0; imm_t = '0; tgt_t = '0; last_t = 1'b0;
        exp2[0] = 32'h3C221234; exp2[1] = 32'hC8221800;
        exp2[2] = 32'h08000010; exp2[3] = 32'h00221800;

        // ---- reset values
        repeat (2) tick();
        check("rst_ready", a_ready, 1'b0);
        check("rst_we",    a_we,    1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_done",  a_done,  1'b0);
        check("rst_err",   a_err,   1'b0);
        check("rst_addr",  a_addr,  8'h00);
        check("rst_wdata", a_wdata, 32'h0);
        check("rst_count", a_count, 9'h0);
        check("rst_addr_base", c_addr, 8'hFE);
        rst_n = 1'b1;
        tick();

        // ---- 1: single ori with last, exact latency
        sel = 0;
        do_start();
        check("t1_busy",  busy_s,  1'b1);
        check("t1_ready", ready_s, 1'b1);
        send(3'b001, 5'd0, 5'd8, 5'd0, 16'h00FF, 26'h0, 1'b1);
        check("t1_we",    we_s,    1'b1);
        check("t1_addr",  addr_s,  8'h00);
        check("t1_wdata", wdata_s, 32'h340800FF);
        check("t1_ready_after_last", ready_s, 1'b0);
        tick();
        check("t1_done",  done_s,  1'b1);
        check("t1_count", count_s, 9'd1);
        check("t1_we_off", we_s,   1'b0);
        check("t1_busy_off", busy_s, 1'b0);

        // ---- 2: four op classes back-to-back
        qa.delete(); ta.delete();
        do_start();
        check("t2_count_clear", count_s, 9'd0);
        send(3'b000, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h10, 1'b0);
        send(3'b010, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h10, 1'b0);
        send(3'b100, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h10, 1'b0);
        send(3'b110, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h10, 1'b1);
        wait_done("t2_done");
        check("t2_nwrites", qa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < qa.size()) check($sformatf("t2_word%0d", i), qa[i], {8'(i), exp2[i]});
            if (i > 0 && i < ta.size()) check($sformatf("t2_b2b%0d", i), ta[i] - ta[i-1], 10);
        end
        check("t2_count", count_s, 9'd4);
        check("t2_err",   err_s,   1'b0);

        // ---- 3: invalid op mid-stream
        qa.delete(); ta.delete();
        do_start();
        send(3'b000, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 1'b0);
        send(3'b101, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 1'b0);
        send(3'b001, 5'd3, 5'd4, 5'd0, 16'hBEEF, 26'h0, 1'b1);
        wait_done("t3_done");
        check("t3_nwrites", qa.size(), 2);
        if (qa.size() >= 2) begin
            check("t3_word0", qa[0], {8'h00, 32'h3C221234});
            check("t3_word1", qa[1], {8'h01, 32'h3464BEEF});
            check("t3_gap",   ta[1] - ta[0], 20);
        end
        check("t3_err",   err_s,   1'b1);
        check("t3_count", count_s, 9'd2);

        // ---- 3b: invalid op carrying in_last still closes the session
        qa.delete(); ta.delete();
        do_start();
        check("t3b_err_clear", err_s, 1'b0);
        send(3'b111, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        check("t3b_done",  done_s,  1'b1);
        check("t3b_err",   err_s,   1'b1);
        tick();
        check("t3b_count", count_s, 9'd0);
        check("t3b_nowrite", qa.size(), 0);

        // ---- 4: capacity limit with ADDR_W=2
        sel = 1;
        qb.delete();
        do_start();
        for (int i = 0; i < 4; i++) send(3'b000, 5'd1, 5'd2, 5'd0, 16'(i), 26'h0, 1'b0);
        check("t4_ready_full", ready_s, 1'b0);
        op_t = 3'b000; imm_t = 16'h0004; last_t = 1'b0; valid_t = 1'b1;
        repeat (3) tick();
        valid_t = 1'b0;
        check("t4_nwrites", qb.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < qb.size()) check($sformatf("t4_word%0d", i), qb[i], {8'(i), 32'h3C220000 + 32'(i)});
        end
        check("t4_done",  done_s,  1'b1);
        check("t4_count", count_s, 9'd4);

        // ---- 5: reset the cycle after an accept
        sel = 0;
        qa.delete(); ta.delete();
        do_start();
        send(3'b000, 5'd1, 5'd2, 5'd0, 16'h5555, 26'h0, 1'b0);
        check("t5_pending", we_s, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_we",    we_s,    1'b0);
        check("t5_addr",  addr_s,  8'h00);
        check("t5_wdata", wdata_s, 32'h0);
        check("t5_count", count_s, 9'd0);
        check("t5_busy",  busy_s,  1'b0);
        check("t5_done",  done_s,  1'b0);
        check("t5_err",   err_s,   1'b0);
        check("t5_ready", ready_s, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_dropped", qa.size(), 0);
        do_start();
        send(3'b001, 5'd0, 5'd8, 5'd0, 16'h00FF, 26'h0, 1'b1);
        wait_done("t5_done_reload");
        check("t5_nwrites", qa.size(), 1);
        if (qa.size() >= 1) check("t5_word0", qa[0], {8'h00, 32'h340800FF});

        // ---- 6: base 0xFE wraps; start in DONE clears err/count
        sel = 2;
        qc.delete();
        do_start();
        send(3'b101, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0, 1'b0);
        send(3'b000, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 1'b0);
        send(3'b001, 5'd0, 5'd8, 5'd0, 16'h00FF, 26'h0, 1'b0);
        send(3'b100, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        wait_done("t6_done");
        check("t6_nwrites", qc.size(), 3);
        if (qc.size() >= 3) begin
            check("t6_word0", qc[0], {8'hFE, 32'h3C221234});
            check("t6_word1", qc[1], {8'hFF, 32'h340800FF});
            check("t6_word2", qc[2], {8'h00, 32'h08000010});
        end
        check("t6_err",   err_s,   1'b1);
        check("t6_count", count_s, 9'd3);
        do_start();
        check("t6_err_clr",   err_s,   1'b0);
        check("t6_count_clr", count_s, 9'd0);
        check("t6_busy",      busy_s,  1'b1);
        check("t6_done_clr",  done_s,  1'b0);
        check("t6_addr_base", addr_s,  8'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
